// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-port RAM arbiter.
// FSM state encoding, default bus widths and the grant-statistics counter width.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 64;
  localparam int STATS_W    = 16;

endpackage

// File: rtl/ram_arbiter_2p_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin pick plus the last-grant register.
// On a tie the requester that did not win last time is picked; last_grant
// only moves when the parent actually grants. Requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       grant,
  output logic       pick
);

  logic last_grant;

  // Combinational pick of the requester to grant this cycle.
  always_comb begin
    // NOTE: pick gets a default before any branch so no latch is inferred.
    pick = 1'b0;
    if (req == 2'b10) begin
      pick = 1'b1;
    end else if (req == 2'b11) begin
      pick = ~last_grant;
    end
  end

  // Remember the most recent winner; reset value 1 hands the first tie to requester 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (grant) begin
      last_grant <= pick;
    end
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p: shares one single-port RAM between two requesters.
// IDLE grants a requester, ACCESS drives the RAM for one cycle, WAIT covers
// the RAM read latency, RESP pulses the winner's rvalid.
// Optional build macro RAM_ARB_STATS_EN adds saturating per-requester grant
// counters grant_cnt0/grant_cnt1.
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [63:0]       ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] grant_cnt0,
  output logic [STATS_W-1:0] grant_cnt1
`endif
);

  state_t      state;
  logic [1:0]  wait_cnt;   // remaining WAIT cycles minus one (RD_LAT <= 4)
  logic        winner;     // id of the requester being served
  logic        lat_write;  // latched request direction
  logic        pick;
  logic        grant_en;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({req1_valid, req0_valid}),
    .grant   (grant_en),
    .pick    (pick)
  );

  // A grant happens only from IDLE, never while reset is held.
  assign grant_en = reset_n && (state == IDLE) && (req0_valid || req1_valid);

  // NOTE: ready is combinational so it pulses in the same cycle the winning
  // valid is seen; the edge closing that cycle is the acceptance edge.
  assign req0_ready = grant_en && !pick;
  assign req1_ready = grant_en &&  pick;

  assign sel_write = pick ? req1_write : req0_write;
  assign sel_addr  = pick ? req1_addr  : req0_addr;
  assign sel_wdata = pick ? req1_wdata : req0_wdata;

  assign busy = (state != IDLE);

  // Main FSM with registered RAM controls, read capture and rvalid pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= 2'd0;
      winner      <= 1'b0;
      lat_write   <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_in      <= '0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
    end else begin
      // NOTE: every register here uses non-blocking assignments so all of
      // them sample pre-edge values; pulses default low and are set below.
      ram_write   <= 1'b0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_en) begin
            winner      <= pick;
            lat_write   <= sel_write;
            ram_write   <= sel_write;
            ram_address <= 64'(sel_addr);
            ram_in      <= sel_wdata;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          wait_cnt <= 2'(RD_LAT - 1);
          state    <= lat_write ? IDLE : WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            if (winner) begin
              req1_rdata  <= ram_out;
              req1_rvalid <= 1'b1;
            end else begin
              req0_rdata  <= ram_out;
              req0_rvalid <= 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef RAM_ARB_STATS_EN
  // Saturating grant counters, one per requester.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (grant_en) begin
      if (!pick && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + STATS_W'(1);
      if ( pick && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// tb_ram_arbiter_2p: self-checking bench for ram_arbiter_2p.
// A behavioural RAM with RD_LAT pipeline sits on the RAM port; expected
// values come from a word array, per-requester last read data and a simple
// alternating-winner model. Define RAM_ARB_STATS_EN to also cover the counters.
module tb_ram_arbiter_2p;

  localparam int AW  = 8;
  localparam int DW  = 64;
  localparam int LAT = 1;

  logic          clock;
  logic          reset_n;
  logic          req0_valid, req0_write, req0_ready, req0_rvalid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_write, req1_ready, req1_rvalid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic [63:0]   ram_address;
  logic [DW-1:0] ram_in, ram_out;
  logic          ram_write;
  logic          busy;
`ifdef RAM_ARB_STATS_EN
  logic [15:0]   grant_cnt0, grant_cnt1;
`endif

  ram_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0_valid  (req0_valid),
    .req0_write  (req0_write),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req0_ready  (req0_ready),
    .req0_rvalid (req0_rvalid),
    .req0_rdata  (req0_rdata),
    .req1_valid  (req1_valid),
    .req1_write  (req1_write),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_ready  (req1_ready),
    .req1_rvalid (req1_rvalid),
    .req1_rdata  (req1_rdata),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_write   (ram_write),
    .ram_out     (ram_out),
    .busy        (busy)
`ifdef RAM_ARB_STATS_EN
    ,
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAM: synchronous write, read data appears RD_LAT edges after the address.
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] pipe [LAT];
  always @(posedge clock) begin
    if (ram_write) mem[ram_address[7:0]] <= ram_in;
    pipe[0] <= mem[ram_address[7:0]];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_out = pipe[LAT-1];

  // Reference model state.
  logic [DW-1:0] exp_mem [256];
  logic [DW-1:0] model_rdata [2];
  bit            model_last;
  int            model_cnt [2];

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the sampling/driving point 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input bit who, input bit v, input bit wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (who) begin
      req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
    end
  endtask

  // One complete transaction by a single requester, starting in an IDLE cycle.
  task automatic xact(input bit who, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] rd;
    drive(who, 1'b1, wr, a, d);
    #1;
    check("ready_winner", who ? req1_ready : req0_ready, 1);
    check("ready_other",  who ? req0_ready : req1_ready, 0);
    check("busy_c0", busy, 0);
    model_last = who;
    model_cnt[who]++;
    cyc();
    drive(who, 1'b0, 1'b0, '0, '0);
    check("busy_c1", busy, 1);
    check("ram_write_c1", ram_write, wr);
    check("ram_address_c1", ram_address, {56'd0, a});
    if (wr) begin
      check("ram_in_c1", ram_in, d);
      exp_mem[a] = d;
      cyc();
      check("busy_wr_done", busy, 0);
      check("ram_write_off", ram_write, 0);
    end else begin
      for (int k = 0; k < LAT; k++) begin
        cyc();
        check("rvalid_early", {req1_rvalid, req0_rvalid}, 0);
      end
      cyc();
      rd = exp_mem[a];
      check("rvalid_winner", who ? req1_rvalid : req0_rvalid, 1);
      check("rvalid_other",  who ? req0_rvalid : req1_rvalid, 0);
      check("rdata_winner",  who ? req1_rdata  : req0_rdata, rd);
      check("rdata_other_hold", who ? req0_rdata : req1_rdata, model_rdata[!who]);
      model_rdata[who] = rd;
      cyc();
      check("busy_rd_done", busy, 0);
      check("rvalid_off", {req1_rvalid, req0_rvalid}, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_ready"},  {req1_ready, req0_ready}, 0);
    check({tag, "_rvalid"}, {req1_rvalid, req0_rvalid}, 0);
    check({tag, "_ramwr"},  ram_write, 0);
    check({tag, "_ramaddr"}, ram_address, 0);
    check({tag, "_ramin"},  ram_in, 0);
    check({tag, "_rdata0"}, req0_rdata, 0);
    check({tag, "_rdata1"}, req1_rdata, 0);
  endtask

  // Watchdog: the sequence is fixed-length, this only guards against a stuck simulator.
  initial begin
    #(10_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit who;
    int a_rr [2];
    logic [DW-1:0] d_rr [2];
    bit exp_w;

    reset_n = 1'b0;
    drive(0, 1'b1, 1'b1, 8'h33, 64'h1);
    drive(1, 1'b0, 1'b0, '0, '0);
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    model_last = 1'b1;
    model_cnt[0] = 0;
    model_cnt[1] = 0;

    // Reset state, with a request pending that must not be accepted.
    repeat (3) cyc();
    check_reset_outputs("reset");
    drive(0, 1'b0, 1'b0, '0, '0);
    cyc();

    // Release and grant on the first edge: write 0x05.
    reset_n = 1'b1;
    xact(0, 1'b1, 8'h05, 64'hDEADBEEF00000001);

    // Read back by requester 1; rvalid0 must stay low.
    xact(1, 1'b0, 8'h05, '0);
    check("rdata1_deadbeef", req1_rdata, 64'hDEADBEEF00000001);

    // Request from requester 1 raised while busy and dropped before IDLE is ignored.
    drive(0, 1'b1, 1'b0, 8'h05, '0);
    #1;
    check("busy_ign_ready0", req0_ready, 1);
    cyc();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b1, 1'b1, 8'h09, 64'h1234);
    #1;
    check("busy_ign_ready1_access", req1_ready, 0);
    for (int k = 0; k < LAT; k++) begin
      cyc();
      check("busy_ign_ready1_wait", req1_ready, 0);
    end
    cyc();
    check("busy_ign_rvalid0", req0_rvalid, 1);
    check("busy_ign_rdata0", req0_rdata, exp_mem[5]);
    check("busy_ign_ready1_resp", req1_ready, 0);
    model_rdata[0] = exp_mem[5];
    drive(1, 1'b0, 1'b0, '0, '0);
    cyc();
    check("busy_ign_idle", busy, 0);
    cyc();
    check("busy_ign_no_access", {busy, ram_write}, 0);

    // Reset during WAIT: everything clears at once, no late rvalid.
    drive(0, 1'b1, 1'b0, 8'h05, '0);
    #1;
    check("wait_rst_ready0", req0_ready, 1);
    cyc();
    drive(0, 1'b0, 1'b0, '0, '0);
    cyc();
    check("wait_rst_in_wait", busy, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("wait_rst");
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    model_last = 1'b1;
    cyc();
    reset_n = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      check("wait_rst_no_rvalid", {req1_rvalid, req0_rvalid, busy}, 0);
      cyc();
    end
    xact(0, 1'b0, 8'h05, '0);

    // Reset during a write ACCESS: ram_write drops immediately.
    drive(1, 1'b1, 1'b1, 8'h07, 64'hFFFF);
    #1;
    check("acc_rst_ready1", req1_ready, 1);
    cyc();
    drive(1, 1'b0, 1'b0, '0, '0);
    check("acc_rst_ramwr_on", ram_write, 1);
    reset_n = 1'b0;
    #1;
    check("acc_rst_ramwr_off", ram_write, 0);
    check("acc_rst_busy", busy, 0);
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    model_last = 1'b1;
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    cyc();
    reset_n = 1'b1;

    // Both requesters hold write requests: winners must alternate starting with 0.
    a_rr[0] = 'h10; a_rr[1] = 'h30;
    d_rr[0] = {$urandom, $urandom};
    d_rr[1] = {$urandom, $urandom};
    for (int g = 0; g < 8; g++) begin
      drive(0, 1'b1, 1'b1, AW'(a_rr[0]), d_rr[0]);
      drive(1, 1'b1, 1'b1, AW'(a_rr[1]), d_rr[1]);
      #1;
      exp_w = !model_last;
      check("rr_ready0", req0_ready, !exp_w);
      check("rr_ready1", req1_ready, exp_w);
      cyc();
      check("rr_ram_write", ram_write, 1);
      check("rr_ram_address", ram_address, 64'(a_rr[exp_w]));
      check("rr_ram_in", ram_in, d_rr[exp_w]);
      exp_mem[a_rr[exp_w]] = d_rr[exp_w];
      model_last = exp_w;
      model_cnt[exp_w]++;
      a_rr[exp_w]++;
      d_rr[exp_w] = {$urandom, $urandom};
      cyc();
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
`ifdef RAM_ARB_STATS_EN
    check("rr_cnt0", grant_cnt0, 4);
    check("rr_cnt1", grant_cnt1, 4);
`endif
    cyc();

    // Fill all 256 words with random data, then read them back in reverse.
    for (int a = 0; a < 256; a++) begin
      who = 1'($urandom_range(0, 1));
      xact(who, 1'b1, AW'(a), {$urandom, $urandom});
    end
    for (int a = 255; a >= 0; a--) begin
      who = 1'($urandom_range(0, 1));
      xact(who, 1'b0, AW'(a), '0);
    end

`ifdef RAM_ARB_STATS_EN
    // Counter saturation with requester 0 only.
    reset_n = 1'b0;
    #1;
    check("sat_cnt0_reset", grant_cnt0, 0);
    cyc();
    reset_n = 1'b1;
    drive(0, 1'b1, 1'b1, 8'h00, 64'h0);
    for (int g = 0; g < 65540; g++) begin
      cyc();
      cyc();
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    exp_mem[0] = '0;
    cyc();
    check("sat_cnt0", grant_cnt0, 16'hFFFF);
    check("sat_cnt1", grant_cnt1, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
